// File: rtl/rram_train_sequencer_pkg.sv
// Shared types and helpers for the RRAM training sequencer.
package rram_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_RST, S_SET, S_GAP, S_LEARN, S_WAIT, S_DONE
  } state_t;

  localparam int RST_CYCLES_DEF = 2;
  localparam int TIMEOUT_DEF    = 1024;
  localparam int MAX_CH         = 32;

  // Next set bit of mask strictly above cur (cur = -1 asks for the lowest).
  // wrap = 1 when nothing lies above cur; the lowest set bit is then returned.
  // An empty mask also reports wrap.
  function automatic int next_ch(input logic [MAX_CH-1:0] mask, input int cur,
                                 output logic wrap);
    int lo;
    int up;
    lo = 0;
    up = -1;
    for (int i = MAX_CH - 1; i >= 0; i--) begin
      if (mask[i]) lo = i;
      if (mask[i] && i > cur) up = i;
    end
    wrap = (up < 0);
    return wrap ? lo : up;
  endfunction

endpackage

// File: rtl/rram_train_sequencer_if.sv
// Sequencer <-> RRAM control block link: pulses out, learn completion back.
interface rram_train_sequencer_if #(
  parameter int TRAIN_W = 8,
  parameter int NUM_CH  = 4
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic               ctrl_reset;
  logic               set;
  logic               learn;
  logic [CH_W-1:0]    learn_ch;
  logic [TRAIN_W-1:0] iter;
  logic               learn_done;

  modport master (output ctrl_reset, set, learn, learn_ch, iter, input learn_done);
  modport slave  (input ctrl_reset, set, learn, learn_ch, iter, output learn_done);
endinterface

// File: rtl/rram_train_sequencer_timer.sv
// Loadable down-counter timing the RST, SET, GAP and LEARN phases.
module rram_pulse_timer #(
  parameter int PW_W = 8
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            load,
  input  logic [PW_W-1:0] load_val,
  output logic            zero
);
  logic [PW_W-1:0] cnt;

  // Load wins; otherwise count down and park at zero.
  always_ff @(posedge clk) begin
    if (!reset_n)          cnt <= '0;
    else if (load)         cnt <= load_val;
    else if (cnt != '0)    cnt <= cnt - PW_W'(1);
  end

  assign zero = (cnt == '0);
endmodule

// File: rtl/rram_train_sequencer.sv
// Drives the RRAM control block through reset, set and masked learn epochs.
module rram_train_sequencer
  import rram_seq_pkg::*;
#(
  parameter int TRAIN_W    = 8,
  parameter int NUM_CH     = 4,
  parameter int PW_W       = 8,
  parameter int RST_CYCLES = RST_CYCLES_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [TRAIN_W-1:0] train_num,
  input  logic [NUM_CH-1:0]  ch_mask,
  input  logic [PW_W-1:0]    set_width,
  input  logic [PW_W-1:0]    learn_width,
  input  logic [PW_W-1:0]    gap,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic               timeout_err,
  rram_train_sequencer_if.master ctl
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int TW   = $clog2(TIMEOUT + 1);

  state_t             st, nxt, post;
  logic [TRAIN_W-1:0] tn_q, iter_q, s_iter, pend_iter, tgt_iter;
  logic [NUM_CH-1:0]  mask_q;
  logic [PW_W-1:0]    sw_q, lw_q, gap_q, tmr_val;
  logic [CH_W-1:0]    ch_q, s_ch, pend_ch, tgt_ch;
  logic [TW-1:0]      wcnt;
  logic [MAX_CH-1:0]  mask_w;
  logic               cr_q, set_q, learn_q;
  logic               s_done, pend_done, tgt_done, wrap, last_iter;
  logic               wait_last, tmo_hit, tmr_zero, tmr_load;

  rram_pulse_timer #(.PW_W(PW_W)) u_tmr (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  // Next-step decode: where SET/WAIT leads, next state and timer reload.
  always_comb begin
    mask_w = '0;
    mask_w[NUM_CH-1:0] = mask_q;
    wrap = 1'b0;
    // From SET look for the lowest channel, otherwise the one above the current
    s_ch = CH_W'(next_ch(mask_w, (st == S_SET) ? -1 : int'(ch_q), wrap));
    last_iter = ({1'b0, iter_q} + (TRAIN_W+1)'(1)) == {1'b0, tn_q};
    if (st == S_SET) begin
      s_done = (tn_q == '0) || wrap;
      s_iter = '0;
    end else begin
      s_done = wrap && last_iter;
      s_iter = (wrap && !last_iter) ? iter_q + TRAIN_W'(1) : iter_q;
    end
    // GAP replays the step decided when SET/WAIT was left
    tgt_done  = (st == S_GAP) ? pend_done : s_done;
    tgt_ch    = (st == S_GAP) ? pend_ch   : s_ch;
    tgt_iter  = (st == S_GAP) ? pend_iter : s_iter;
    post      = tgt_done ? S_DONE : S_LEARN;
    wait_last = (wcnt == TW'(TIMEOUT - 1));
    tmo_hit   = (st == S_WAIT) && !abort && !ctl.learn_done && wait_last;

    nxt = st;
    case (st)
      S_IDLE:  if (start)    nxt = S_RST;
      S_RST:   if (tmr_zero) nxt = S_SET;
      S_SET:   if (tmr_zero) nxt = (gap_q != '0) ? S_GAP : post;
      S_GAP:   if (tmr_zero) nxt = post;
      S_LEARN: if (tmr_zero) nxt = S_WAIT;
      S_WAIT:  if (ctl.learn_done || wait_last) nxt = (gap_q != '0) ? S_GAP : post;
      S_DONE:  nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
    if (abort && st != S_IDLE) nxt = S_IDLE;

    // Every timed phase is entered from a different state, so a change reloads
    tmr_load = (nxt != st);
    case (nxt)
      S_SET:   tmr_val = (sw_q == '0) ? '0 : sw_q - PW_W'(1);
      S_GAP:   tmr_val = gap_q - PW_W'(1);
      S_LEARN: tmr_val = (lw_q == '0) ? '0 : lw_q - PW_W'(1);
      default: tmr_val = PW_W'(RST_CYCLES - 1);
    endcase
  end

  // State, registered outputs, run configuration and WAIT counter.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      st          <= S_IDLE;
      cr_q        <= 1'b0;
      set_q       <= 1'b0;
      learn_q     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      ch_q        <= '0;
      iter_q      <= '0;
      tn_q        <= '0;
      mask_q      <= '0;
      sw_q        <= '0;
      lw_q        <= '0;
      gap_q       <= '0;
      pend_done   <= 1'b0;
      pend_ch     <= '0;
      pend_iter   <= '0;
      wcnt        <= '0;
    end else begin
      st      <= nxt;
      cr_q    <= (nxt == S_RST);
      set_q   <= (nxt == S_SET);
      learn_q <= (nxt == S_LEARN);
      busy    <= (nxt != S_IDLE);
      done    <= (nxt == S_DONE);
      if (st == S_IDLE && start) begin
        tn_q        <= train_num;
        mask_q      <= ch_mask;
        sw_q        <= set_width;
        lw_q        <= learn_width;
        gap_q       <= gap;
        timeout_err <= 1'b0;
        ch_q        <= '0;
        iter_q      <= '0;
      end
      if (tmo_hit) timeout_err <= 1'b1;
      if ((st == S_SET || st == S_WAIT) && nxt == S_GAP) begin
        pend_done <= s_done;
        pend_ch   <= s_ch;
        pend_iter <= s_iter;
      end
      if (nxt == S_LEARN && st != S_LEARN) begin
        ch_q   <= tgt_ch;
        iter_q <= tgt_iter;
      end
      if (st != S_WAIT)   wcnt <= '0;
      else if (!wait_last) wcnt <= wcnt + TW'(1);
    end
  end

  assign ctl.ctrl_reset = cr_q;
  assign ctl.set        = set_q;
  assign ctl.learn      = learn_q;
  assign ctl.learn_ch   = ch_q;
  assign ctl.iter       = iter_q;
endmodule

// File: tb/tb_rram_train_sequencer.sv
// Bench for rram_train_sequencer: per-run cycle trace from a phase-level model.
module tb_rram_train_sequencer;
  localparam int TRAIN_W = 8;
  localparam int NUM_CH  = 4;
  localparam int PW_W    = 8;
  localparam int RST_CYC = 2;
  localparam int TMO     = 16;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               start = 1'b0;
  logic               abort = 1'b0;
  logic [TRAIN_W-1:0] train_num = '0;
  logic [NUM_CH-1:0]  ch_mask = '0;
  logic [PW_W-1:0]    set_width = '0;
  logic [PW_W-1:0]    learn_width = '0;
  logic [PW_W-1:0]    gap = '0;
  logic               busy, done, timeout_err;

  rram_train_sequencer_if #(.TRAIN_W(TRAIN_W), .NUM_CH(NUM_CH)) ctl ();

  rram_train_sequencer #(
    .TRAIN_W(TRAIN_W), .NUM_CH(NUM_CH), .PW_W(PW_W),
    .RST_CYCLES(RST_CYC), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .train_num(train_num),
    .ch_mask(ch_mask), .set_width(set_width), .learn_width(learn_width),
    .gap(gap), .abort(abort), .busy(busy), .done(done),
    .timeout_err(timeout_err), .ctl(ctl)
  );

  always #5 clk = ~clk;

  // One expected cycle; wt/drv are stimulus hints, not compared
  typedef struct {
    bit cr, st, ln;
    int ch, it;
    bit bz, dn, to, wt, drv;
  } cyc_t;

  cyc_t exp_q[$];
  int   m_ch, m_it;
  bit   m_to;
  int   n_chk, n_fail;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  function automatic logic [15:0] obs();
    return {ctl.ctrl_reset, ctl.set, ctl.learn, ctl.learn_ch, ctl.iter, busy, done, timeout_err};
  endfunction

  function automatic logic [15:0] pk(input cyc_t c);
    return {c.cr, c.st, c.ln, 2'(c.ch), 8'(c.it), c.bz, c.dn, c.to};
  endfunction

  function automatic logic [15:0] pk_idle(input cyc_t c);
    return {3'b000, 2'(c.ch), 8'(c.it), 2'b00, c.to};
  endfunction

  task automatic push(input bit cr, st, ln, bz, dn, wt, drv);
    cyc_t c;
    c.cr = cr; c.st = st; c.ln = ln; c.bz = bz; c.dn = dn; c.wt = wt; c.drv = drv;
    c.ch = m_ch; c.it = m_it; c.to = m_to;
    exp_q.push_back(c);
  endtask

  // Phase-level model. dmode: 0 fixed delay dfix, 1 small random, 2 mix with timeouts
  task automatic build(input int tn, mask, sw, lw, gp, dmode, dfix);
    exp_q.delete();
    m_ch = 0; m_it = 0; m_to = 1'b0;
    repeat (RST_CYC) push(1, 0, 0, 1, 0, 0, 0);
    repeat ((sw == 0) ? 1 : sw) push(0, 1, 0, 1, 0, 0, 0);
    repeat (gp) push(0, 0, 0, 1, 0, 0, 0);
    if (tn != 0 && mask != 0)
      for (int e = 0; e < tn; e++)
        for (int c = 0; c < NUM_CH; c++)
          if (mask[c]) begin
            int d;
            m_ch = c; m_it = e;
            repeat ((lw == 0) ? 1 : lw) push(0, 0, 1, 1, 0, 0, 0);
            if (dmode == 0)      d = dfix;
            else if (dmode == 1) d = int'($urandom_range(0, 5));
            else                 d = ($urandom % 4 == 0) ? TMO + 3 : int'($urandom_range(0, TMO - 1));
            if (d < TMO) begin
              for (int k = 0; k <= d; k++) push(0, 0, 0, 1, 0, 1, k == d);
            end else begin
              repeat (TMO) push(0, 0, 0, 1, 0, 1, 0);
              m_to = 1'b1;
            end
            repeat (gp) push(0, 0, 0, 1, 0, 0, 0);
          end
    push(0, 0, 0, 1, 1, 0, 0);
    push(0, 0, 0, 0, 0, 0, 0);
  endtask

  // -1 none, -2 second learn cycle, -3 last WAIT cycle before timeout, -4 random
  function automatic int resolve(input int code);
    if (code >= -1) return code;
    if (code == -4) return int'($urandom_range(0, exp_q.size() - 2));
    foreach (exp_q[i]) begin
      if (code == -2 && exp_q[i].ln) return i + 1;
      if (code == -3 && exp_q[i].wt) return i + TMO - 1;
    end
    return -1;
  endfunction

  task automatic run(input int tn, mask, sw, lw, gp, dmode, dfix, ab_code, rs_code,
                     input bit noise, input string tag);
    int n, ab, rs;
    build(tn, mask, sw, lw, gp, dmode, dfix);
    n  = exp_q.size();
    ab = resolve(ab_code);
    rs = resolve(rs_code);
    train_num = TRAIN_W'(tn); ch_mask = NUM_CH'(mask);
    set_width = PW_W'(sw); learn_width = PW_W'(lw); gap = PW_W'(gp);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int t = 0; t < n; t++) begin
      chk($sformatf("%s c%0d", tag, t), obs(), pk(exp_q[t]));
      ctl.learn_done = exp_q[t].drv;
      if (noise) begin
        if (!exp_q[t].wt) ctl.learn_done = 1'($urandom % 2);
        if (t < n - 1) start = 1'($urandom % 2);
        train_num = TRAIN_W'($urandom); ch_mask = NUM_CH'($urandom);
        set_width = PW_W'($urandom); learn_width = PW_W'($urandom); gap = PW_W'($urandom);
      end
      abort = (t == ab);
      if (t == ab && ab_code != -3) ctl.learn_done = 1'b1;
      reset_n = (t != rs);
      @(posedge clk); #1;
      start = 1'b0; abort = 1'b0; ctl.learn_done = 1'b0;
      if (t == ab) begin
        chk({tag, " abort"}, obs(), pk_idle(exp_q[t]));
        @(posedge clk); #1;
        chk({tag, " abort hold"}, obs(), pk_idle(exp_q[t]));
        break;
      end
      if (t == rs) begin
        chk({tag, " midrun reset"}, obs(), 16'h0000);
        break;
      end
    end
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    ctl.learn_done = 1'b0;
    reset_n = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("reset", obs(), 16'h0000);
    end
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("idle after reset", obs(), 16'h0000);

    run(0, 4'b0001, 3, 2, 0, 0, 0, -1, -1, 0, "t1 no epochs");
    run(2, 4'b1010, 2, 3, 2, 0, 1, -1, -1, 0, "t2 sweep");
    run(1, 4'b0011, 1, 1, 0, 0, TMO + 5, -1, -1, 0, "t3 timeout");
    run(1, 4'b0100, 2, 2, 1, 0, 2, -1, -1, 0, "t3 clear");
    run(2, 4'b0110, 2, 4, 1, 1, 0, -2, -1, 0, "t4 abort learn");
    run(1, 4'b0100, 1, 1, 0, 0, TMO + 5, -3, -1, 0, "t4 abort vs timeout");
    run(2, 4'b1101, 3, 2, 2, 1, 0, -1, -1, 1, "t5 noise");
    run(2, 4'b1111, 1, 3, 1, 1, 0, -1, -2, 0, "t6 reset in learn");
    run(1, 4'b1001, 2, 2, 1, 1, 0, -1, -1, 0, "t6 after reset");
    run(3, 4'b0000, 1, 1, 1, 0, 0, -1, -1, 0, "empty mask");
    run(1, 4'b1111, 0, 0, 0, 0, 0, -1, -1, 0, "zero widths");
    run(255, 4'b0001, 0, 0, 0, 0, 0, -1, -1, 0, "max epochs");
    for (int r = 0; r < 10; r++) begin
      int ab;
      ab = ($urandom % 4 == 0) ? -4 : -1;
      run(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)), int'($urandom_range(0, 4)),
          int'($urandom_range(0, 4)), int'($urandom_range(0, 3)), 2, 0, ab, -1,
          1'($urandom % 2), $sformatf("rnd%0d", r));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
